// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word lines and a single
// outstanding refill; also keeps hit/miss performance counters.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    input  logic        inv,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = 30 - IDX;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t          state_q;
    logic [SETS-1:0] valid_q;
    logic [TAGW-1:0] tag_q  [SETS];
    logic [31:0]     data_q [SETS];
    logic [IDX-1:0]  miss_idx_q;
    logic [TAGW-1:0] miss_tag_q;
    logic [31:0]     hit_count_q;
    logic [31:0]     miss_count_q;

    logic [IDX-1:0]  idx_s;
    logic [TAGW-1:0] tag_s;
    logic            hit_s;
    logic            fill_s;
    logic            unused_s;

    assign idx_s    = imemaddr[IDX+1:2];
    assign tag_s    = imemaddr[31:IDX+2];
    assign unused_s = &{1'b0, imemaddr[1:0]};

    assign hit_s  = (state_q == IDLE) && imemREN && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign fill_s = (state_q == FETCH) && !iwait;

    assign ihit       = hit_s;
    assign imemload   = hit_s ? data_q[idx_s] : 32'd0;
    assign iREN       = (state_q == FETCH);
    assign iaddr      = {miss_tag_q, miss_idx_q, 2'b00};
    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    // Controller: state, valid bits, latched miss address and counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
            hit_count_q  <= 32'd0;
            miss_count_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (imemREN && !hit_s) begin
                        miss_idx_q   <= idx_s;
                        miss_tag_q   <= tag_s;
                        miss_count_q <= miss_count_q + 32'd1;
                        state_q      <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        valid_q[miss_idx_q] <= 1'b1;
                        state_q             <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (hit_s) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            // Invalidate is ordered last so it wins over a same-cycle fill.
            if (inv) begin
                valid_q <= '0;
            end
        end
    end

    // Tag/data storage needs no reset; the valid bits guard it.
    always_ff @(posedge CLK) begin
        if (fill_s) begin
            tag_q[miss_idx_q]  <= miss_tag_q;
            data_q[miss_idx_q] <= iload;
        end
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port. It answers fetch requests from a valid/tag/data array and asserts `ihit` combinationally on a hit. On a miss it latches the address and issues a one-word refill to memory, holding `iREN` until `iwait` drops, then writes the line. It also keeps hit and miss counters for performance runs.

## Interface
Parameters:
- `SETS`, 16: number of one-word lines; power of two, at least 2; `IDX = log2(SETS)`.

Ports:
- `CLK`  in  1: clock; all state changes on the rising edge.
- `nRST`  in  1: asynchronous, active-low reset.
- `imemREN`  in  1: fetch request from the datapath.
- `imemaddr`  in  32: fetch byte address; bits [1:0] ignored.
- `ihit`  out  1: requested word is valid on `imemload` this cycle.
- `imemload`  out  32: fetched instruction; 0 when `ihit`=0.
- `iREN`  out  1: refill request to the memory controller.
- `iaddr`  out  32: refill word address, always {miss_tag, miss_idx, 2'b00}.
- `iwait`  in  1: memory busy; a refill completes in a FETCH cycle with `iwait`=0.
- `iload`  in  32: refill data, sampled when `iwait`=0 in FETCH.
- `inv`  in  1: invalidate all lines.
- `hit_count`  out  32: hit cycles since reset.
- `miss_count`  out  32: misses since reset.

## Operation
- Address split: index = `imemaddr[IDX+1:2]`; tag = `imemaddr[31:IDX+2]` (26 bits when SETS=16).
- Storage per line: valid bit, tag, 32-bit data. The array is flip-flop based with combinational read.
- State machine with two states, IDLE and FETCH:
  - **IDLE**:
    - `hit` = `imemREN` & valid[idx] & (tag[idx] == tag).
    - `ihit` = `hit`; `imemload` = data[idx] when `hit`, else 0.
    - `iREN` = 0.
    - If `imemREN` & !`hit`: latch miss_idx and miss_tag from `imemaddr`, go to FETCH, increment `miss_count`.
  - **FETCH**:
    - `ihit` = 0, `imemload` = 0, `iREN` = 1.
    - `iaddr` comes from the latched registers. It does not follow `imemaddr`, which may change due to a redirect or a branch-predictor correction.
    - When `iwait`=0: write data[miss_idx] = `iload`, tag[miss_idx] = miss_tag, valid[miss_idx] = 1; go to IDLE.
    - While `iwait`=1: stay in FETCH.
- Refills are never aborted. Deasserting `imemREN` (halt) or changing `imemaddr` during FETCH does not cancel the refill.
- Replacement: a refill overwrites the indexed line unconditionally, so conflicting tags evict each other.
- `inv`: on the next edge all valid bits clear.
  - `inv` has priority over a simultaneous refill write; that line ends invalid.
  - `inv` does not change state; a FETCH in progress still completes its handshake.
- Counters:
  - `hit_count` increments on every cycle with `ihit`=1, including repeated cycles while the datapath is stalled on the same address.
  - `miss_count` increments on each IDLE→FETCH transition.
  - Both counters are unsigned and wrap modulo 2^32 (0xFFFFFFFF + 1 = 0).
- `iaddr` in IDLE shows the last latched miss address. The memory controller ignores it when `iREN`=0.

## Timing
- Reset (async on `nRST` low):
  - State goes to IDLE, all valid bits clear, miss_idx and miss_tag clear.
  - Outputs: `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0, `hit_count`=0, `miss_count`=0.
  - Reset asserted mid-refill abandons the refill.
- Hit latency: 0 cycles; `ihit` is combinational from `imemaddr` in IDLE.
- Miss timing, with the miss detected in cycle t:
  - FETCH and `iREN`=1 from t+1.
  - If `iwait` first reads 0 at cycle t+k (k≥1), the line is written at the t+k edge, state is IDLE at t+k+1, and `ihit`=1 at t+k+1 if the address is unchanged.
  - Minimum miss-to-hit time is 2 cycles.
- Back-to-back misses: the cycle after a refill completes is an IDLE lookup. A new miss enters FETCH one cycle later, so `iREN` drops for at least one cycle between refills.
- `imemREN`=0 in IDLE gives no request, no hit, and no counter change.

## Test plan
- **Reset:** assert `nRST`=0 mid-FETCH, then release → `iREN`=0, `ihit`=0, both counters 0. Then `imemREN`=1, `imemaddr`=0x0 → `iREN`=1 and `iaddr`=0x0 in the next cycle.
- **Cold miss:** `imemaddr`=0x40, `iwait`=1 for 3 FETCH cycles then 0 with `iload`=0x20010005 → next cycle `ihit`=1, `imemload`=0x20010005, `miss_count`=1; 4 further hit cycles → `hit_count`=5.
- **Conflict:** fill 0x40, then fetch 0x80 (same index 0, tag 2) → miss with `iaddr`=0x80. Refetch 0x40 → misses again; `miss_count`=3.
- **Redirect mid-miss:** miss on 0x104, change `imemaddr` to 0x200 while `iwait`=1 → `iaddr` stays 0x104. After the fill, 0x200 misses. 0x104 later hits with no new request.
- **Invalidate:** pulse `inv` in the same cycle the refill completes → that line is invalid and refetching it misses. Pulse `inv` in IDLE after a fill of 0x40 → 0x40 misses.
- **Halt:** drop `imemREN` during FETCH → the refill still completes when `iwait`=0. Afterwards `ihit`=0, and neither counter changes while `imemREN`=0.
